ripple_ctr_capture: RTL and testbench
=====================================

# ripple_ctr_capture

Downstream consumer of the ripple counter. Takes its asynchronously settling count output, brings it into the `clk_i` domain, and rejects mid-ripple values with a stability filter. It unwraps count deltas modulo 2^Width and reports the number of counted events per fixed window of `clk_i` cycles. Typical use is a frequency/event-rate meter for a slow or externally clocked source.

## Interface
- `Width`, 4: width of the ripple counter value on `cnt_i`.
- `RateWidth`, 16: width of `rate_o` and of the internal window accumulator.
- `Window`, 1000: window length in `clk_i` cycles; legal range is 2 to 2^32-1.
- `CountDown`, 0: set to 1 when the upstream counter decrements, so delta = old - new.
- `clk_i`, input, 1: single system clock; all state is on its rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset. Asserting it clears all state immediately; deassertion is synchronous to `clk_i` by the system.
- `cnt_i`, input, Width: ripple counter value, asynchronous to `clk_i`.
- `clear_i`, input, 1: synchronous restart of the window. Discards the partial window and re-primes.
- `rate_o`, output, RateWidth: event count of the last completed window; held until the next report.
- `rate_valid_o`, output, 1: one-cycle pulse when `rate_o` updates.
- `sat_o`, output, 1: the last reported window saturated; updated together with `rate_o`.

## Operation
- **Synchronizer.** Two flops `sync1` and `sync2` capture `cnt_i`. Metastability tolerance is per bit only.
- **Stability filter.**
  - `hold` register holds `sync2` delayed by one cycle.
  - A sample is *accepted* on a cycle where `sync2 == hold`.
  - Unequal cycles are ignored; they cover ripple transients.
- **FSM states:**
  - `PRIME`, the reset and `clear_i` target. On the first accepted sample: `last <= sample`, no delta, go to `RUN`.
  - `RUN`. On each accepted sample: `delta = (sample - last) mod 2^Width`, or `(last - sample)` when `CountDown`; then `last <= sample`.
- **Accumulator.**
  - `acc += delta`, zero-extended to RateWidth and saturating at all-ones.
  - Saturation sets the internal `sat` flag.
- **Window.**
  - `wcnt` counts 0 to Window-1 in both states and wraps.
  - On the cycle with `wcnt == Window-1`: `rate_o <= acc_next`, `sat_o <= sat_next`, pulse `rate_valid_o`, then `acc <= 0` and `sat <= 0`.
  - `acc_next` and `sat_next` include any delta accepted on that same cycle.
- **Wrap-around.** Upstream value 15 → 0 (Width=4, up) gives delta 1.
- **Source constraint.** The source must advance fewer than 2^Width counts between accepted samples. Faster sources alias; this is not detected.
- **`clear_i`.** Takes priority over window end and accept in the same cycle: `wcnt <= 0`, `acc <= 0`, `sat <= 0`, state → `PRIME`, no pulse. `rate_o` and `sat_o` hold their values.
- **`rst_i`.** Clears everything at any time, including mid-window. The next report is a full Window after release.

## Timing
- **Reset values:** `rate_o = 0`, `rate_valid_o = 0`, `sat_o = 0`. Internally `sync1 = sync2 = hold = last = 0`, `acc = 0`, `wcnt = 0`, state `PRIME`.
- **Capture latency.** `cnt_i` stable before edge k:
  - `sync2` valid after edge k+1.
  - `hold` matches after edge k+2.
  - Accepted at edge k+3; `acc` reflects it after edge k+3.
- **Report cadence.** The first `rate_valid_o` is high in the cycle after edge Window-1 following reset release. It then repeats every Window cycles.
- **Source period.** A source count that holds steady for at least 2 `clk_i` cycles is always accepted.
- No backpressure. Pulses are not queued; the consumer must sample `rate_o` on `rate_valid_o`.

## Structure
- Package `ripple_cap_pkg` contains:
  - `cap_state_e` enum: `PRIME`, `RUN`.
  - A width helper for `wcnt` (`$clog2(Window)`).
- Sub-module `sync_2ff`, parameterised by width, implements the two-flop synchronizer with async active-high reset. It is reused elsewhere.
- The top level holds the filter, FSM, accumulator and window counter.

## Test plan
- **Basic rate.** Width=4, Window=100, `cnt_i` steps +1 every 10 cycles, held stable → `rate_o` = 10 (±1 on the first window only), `sat_o` = 0.
- **Wrap.** `cnt_i` sequence 14, 15, 0, 1, each held 5 cycles, after priming on 14 → accumulated delta 3.
- **Glitch rejection.** `cnt_i` 7 → 8 passing through single-cycle 15 and 12 transients → delta exactly 1, no spurious counts.
- **Saturation.** RateWidth=4, Window=200, source +1 every 4 cycles → `rate_o` = 15, `sat_o` = 1; the next window at a slower rate → `sat_o` = 0.
- **Clear/reset.** `clear_i` asserted on the window-end cycle → no pulse, `rate_o` unchanged, next pulse Window cycles later. `rst_i` asserted mid-window → all outputs 0 immediately.
- **CountDown=1.** `cnt_i` 3 → 2 → 1 → 0 → 15 → delta total 4.

Source files
------------

// File: rtl/ripple_cap_pkg.sv
// Shared types and helpers for the ripple counter capture block.
package ripple_cap_pkg;

    // PRIME waits for a first trustworthy sample to use as the delta
    // reference; RUN turns every accepted sample into a count delta.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } cap_state_e;

    // Width of the window counter that runs 0 .. window-1.
    // Never returns less than one bit so degenerate windows still elaborate.
    function automatic int wcnt_width(input longint unsigned window);
        int w;
        w = $clog2(window);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : ripple_cap_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus whose bits are metastability-tolerant
// individually; it gives no guarantee of multi-bit coherence.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;

    // Two back-to-back capture stages; reset clears both immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule : sync_2ff

// File: rtl/ripple_ctr_capture.sv
// Captures an asynchronously settling ripple counter value, filters out
// mid-ripple samples, unwraps deltas modulo 2^Width and reports the number
// of counted events per fixed window of clk_i cycles.
//
// Output handshake: rate_valid_o is a one-cycle pulse with no ready/backpressure.
// rate_o and sat_o change only in the cycle rate_valid_o is high and hold
// otherwise; a consumer that misses the pulse misses that report.
module ripple_ctr_capture
    import ripple_cap_pkg::*;
#(
    parameter int unsigned Width     = 4,
    parameter int unsigned RateWidth = 16,
    parameter int unsigned Window    = 1000,
    parameter bit          CountDown = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [Width-1:0]     cnt_i,
    input  logic                 clear_i,
    output logic [RateWidth-1:0] rate_o,
    output logic                 rate_valid_o,
    output logic                 sat_o
);

    localparam int WcntW = wcnt_width(longint'(Window));
    localparam logic [WcntW-1:0] WcntLast = WcntW'(Window - 1);

    // Sum is wide enough for the accumulator plus one delta with carry,
    // whichever of the two is wider.
    localparam int SumW = ((Width > RateWidth) ? Width : RateWidth) + 1;
    localparam logic [SumW-1:0] AccMax = {{(SumW - RateWidth){1'b0}}, {RateWidth{1'b1}}};

    logic [Width-1:0]     sync2;
    logic [Width-1:0]     hold_q;
    logic [Width-1:0]     last_q,  last_d;
    cap_state_e           state_q, state_d;
    logic [RateWidth-1:0] acc_q,   acc_d;
    logic                 sat_q,   sat_d;
    logic [WcntW-1:0]     wcnt_q,  wcnt_d;
    logic [RateWidth-1:0] rate_q,  rate_d;
    logic                 rsat_q,  rsat_d;
    logic                 valid_q, valid_d;

    logic                 accept;
    logic [Width-1:0]     delta;
    logic [SumW-1:0]      sum;
    logic [RateWidth-1:0] acc_next;
    logic                 sat_next;

    sync_2ff #(
        .Width(Width)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (cnt_i),
        .q_o  (sync2)
    );

    // Delay the synchronized value by one cycle for the stability compare.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else begin
            hold_q <= sync2;
        end
    end

    // A sample is trusted only when it matches the previous cycle, which
    // drops the transient codes seen while the ripple counter settles.
    // The delta wraps naturally in Width bits, unwrapping 15 -> 0 as +1.
    always_comb begin
        accept = (sync2 == hold_q);
        delta  = CountDown ? (last_q - sync2) : (sync2 - last_q);
    end

    // Accumulate with saturation; only RUN produces deltas, PRIME just
    // establishes the reference value.
    always_comb begin
        sum      = SumW'(acc_q) + SumW'(delta);
        acc_next = acc_q;
        sat_next = sat_q;
        if (accept && (state_q == RUN)) begin
            if (sum > AccMax) begin
                acc_next = '1;
                sat_next = 1'b1;
            end else begin
                acc_next = sum[RateWidth-1:0];
            end
        end
    end

    // FSM next state plus window bookkeeping. clear_i wins over both the
    // window end and an accepted sample; the reported outputs are left alone.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        wcnt_d  = wcnt_q;
        rate_d  = rate_q;
        rsat_d  = rsat_q;
        valid_d = 1'b0;

        if (clear_i) begin
            state_d = PRIME;
            acc_d   = '0;
            sat_d   = 1'b0;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                PRIME: begin
                    if (accept) begin
                        last_d  = sync2;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        last_d = sync2;
                    end
                end
                default: begin
                    state_d = PRIME;
                end
            endcase

            if (wcnt_q == WcntLast) begin
                rate_d  = acc_next;
                rsat_d  = sat_next;
                valid_d = 1'b1;
                acc_d   = '0;
                sat_d   = 1'b0;
                wcnt_d  = '0;
            end else begin
                acc_d   = acc_next;
                sat_d   = sat_next;
                wcnt_d  = wcnt_q + WcntW'(1);
            end
        end
    end

    // State, accumulator, window counter and report registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PRIME;
            last_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            wcnt_q  <= '0;
            rate_q  <= '0;
            rsat_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            wcnt_q  <= wcnt_d;
            rate_q  <= rate_d;
            rsat_q  <= rsat_d;
            valid_q <= valid_d;
        end
    end

    assign rate_o       = rate_q;
    assign rate_valid_o = valid_q;
    assign sat_o        = rsat_q;

endmodule : ripple_ctr_capture

// File: tb/tb_ripple_ctr_capture.sv
// Bench for ripple_ctr_capture: an up-counting instance with a wide rate
// and a down-counting instance with a 4-bit rate, checked every cycle
// against a window-level reference model plus directed scenario checks.
module tb_ripple_ctr_capture;

    localparam int Mod = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  cnt_a, cnt_b;
    logic        clr_a, clr_b;
    logic [15:0] rate_a;
    logic [3:0]  rate_b;
    logic        valid_a, valid_b, sat_a, sat_b;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state, index 0 = up instance, 1 = down instance
    int unsigned m_win  [2] = '{100, 200};
    int          m_max  [2] = '{65535, 15};
    bit          m_down [2] = '{1'b0, 1'b1};
    int          seen_q0[$];
    int          seen_q1[$];
    int          prev_s [2];
    int          last_v [2];
    int          acc    [2];
    int          wpos   [2];
    bit          primed [2];
    bit          sat    [2];
    int          exp_valid[2];
    int          exp_rate [2];
    int          exp_sat  [2];
    logic        got_valid[2];

    logic [31:0] rep_a[$], rsat_a[$], rep_b[$], rsat_b[$];

    ripple_ctr_capture #(
        .Width(4), .RateWidth(16), .Window(100), .CountDown(1'b0)
    ) u_up (
        .clk_i(clk), .rst_i(rst), .cnt_i(cnt_a), .clear_i(clr_a),
        .rate_o(rate_a), .rate_valid_o(valid_a), .sat_o(sat_a)
    );

    ripple_ctr_capture #(
        .Width(4), .RateWidth(4), .Window(200), .CountDown(1'b1)
    ) u_dn (
        .clk_i(clk), .rst_i(rst), .cnt_i(cnt_b), .clear_i(clr_b),
        .rate_o(rate_b), .rate_valid_o(valid_b), .sat_o(sat_b)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        seen_q0 = '{0, 0};
        seen_q1 = '{0, 0};
        for (int i = 0; i < 2; i++) begin
            prev_s[i]    = 0;
            last_v[i]    = 0;
            acc[i]       = 0;
            wpos[i]      = 0;
            primed[i]    = 1'b0;
            sat[i]       = 1'b0;
            exp_valid[i] = 0;
            exp_rate[i]  = 0;
            exp_sat[i]   = 0;
        end
    endtask

    // One clk_i edge of the reference: the value seen is the one driven two
    // edges earlier, trusted only if unchanged from the previous edge.
    task automatic model_step(input int i, input int cnt, input bit clr);
        int  s;
        int  d;
        int  tot;
        bit  stable;
        if (i == 0) begin
            s = seen_q0.pop_front();
            seen_q0.push_back(cnt);
        end else begin
            s = seen_q1.pop_front();
            seen_q1.push_back(cnt);
        end
        stable       = (s == prev_s[i]);
        prev_s[i]    = s;
        exp_valid[i] = 0;
        if (clr) begin
            acc[i]    = 0;
            sat[i]    = 1'b0;
            wpos[i]   = 0;
            primed[i] = 1'b0;
        end else begin
            if (stable) begin
                if (!primed[i]) begin
                    primed[i] = 1'b1;
                end else begin
                    d   = m_down[i] ? (last_v[i] - s) : (s - last_v[i]);
                    d   = (d + Mod) % Mod;
                    tot = acc[i] + d;
                    if (tot > m_max[i]) begin
                        acc[i] = m_max[i];
                        sat[i] = 1'b1;
                    end else begin
                        acc[i] = tot;
                    end
                end
                last_v[i] = s;
            end
            wpos[i]++;
            if (wpos[i] == int'(m_win[i])) begin
                exp_valid[i] = 1;
                exp_rate[i]  = acc[i];
                exp_sat[i]   = sat[i];
                acc[i]       = 0;
                sat[i]       = 1'b0;
                wpos[i]      = 0;
            end
        end
    endtask

    // Driver: one clock with the current inputs, then compare at the falling edge
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_step(0, int'(cnt_a), clr_a);
            model_step(1, int'(cnt_b), clr_b);
        end
        @(negedge clk);
        got_valid[0] = valid_a;
        got_valid[1] = valid_b;
        check("up_valid", valid_a, exp_valid[0]);
        check("up_rate",  rate_a,  exp_rate[0]);
        check("up_sat",   sat_a,   exp_sat[0]);
        check("dn_valid", valid_b, exp_valid[1]);
        check("dn_rate",  rate_b,  exp_rate[1]);
        check("dn_sat",   sat_b,   exp_sat[1]);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    task automatic wait_report(input int i, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!got_valid[i] && n < budget);
        check((i == 0) ? "up_wait_valid" : "dn_wait_valid", got_valid[i], 1);
    endtask

    task automatic check_zero_outputs();
        check("rst_up_rate",  rate_a,  0);
        check("rst_up_valid", valid_a, 0);
        check("rst_up_sat",   sat_a,   0);
        check("rst_dn_rate",  rate_b,  0);
        check("rst_dn_valid", valid_b, 0);
        check("rst_dn_sat",   sat_b,   0);
    endtask

    initial begin
        int n;
        int v;
        int hold;
        int total;

        rst   = 1'b1;
        cnt_a = '0;
        cnt_b = '0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        model_reset();
        #1;
        check_zero_outputs();
        ticks(3);
        rst = 1'b0;

        // Basic rate on the up instance; saturation then slow rate on the down one
        for (int c = 0; c < 400; c++) begin
            cnt_a = 4'((c / 10) % Mod);
            v     = (c < 200) ? (c / 4) : (50 + (c - 200) / 20);
            cnt_b = 4'((Mod - (v % Mod)) % Mod);
            tick();
            if (valid_a) begin
                rep_a.push_back(32'(rate_a));
                rsat_a.push_back(32'(sat_a));
            end
            if (valid_b) begin
                rep_b.push_back(32'(rate_b));
                rsat_b.push_back(32'(sat_b));
            end
        end
        check("up_nreports", rep_a.size(), 4);
        check("dn_nreports", rep_b.size(), 2);
        if (rep_a.size() >= 3) begin
            check("up_rate_w2", rep_a[1], 10);
            check("up_rate_w3", rep_a[2], 10);
            check("up_sat_w2",  rsat_a[1], 0);
        end
        if (rep_b.size() >= 2) begin
            check("dn_sat_rate", rep_b[0], 15);
            check("dn_sat_flag", rsat_b[0], 1);
            check("dn_slow_rate", rep_b[1], 10);
            check("dn_slow_sat",  rsat_b[1], 0);
        end

        // Wrap-around 14 -> 15 -> 0 -> 1 after priming on 14
        cnt_a = 4'd14;
        ticks(5);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        ticks(4);
        cnt_a = 4'd15;
        ticks(5);
        cnt_a = 4'd0;
        ticks(5);
        cnt_a = 4'd1;
        wait_report(0, 200, n);
        check("up_wrap_rate", rate_a, 3);
        check("up_wrap_lat",  n, 86);

        // Glitch rejection: 7 -> 8 via single-cycle 15 and 12
        cnt_a = 4'd7;
        ticks(5);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        ticks(4);
        cnt_a = 4'd15;
        tick();
        cnt_a = 4'd12;
        tick();
        cnt_a = 4'd8;
        wait_report(0, 200, n);
        check("up_glitch_rate", rate_a, 1);
        check("up_glitch_sat",  sat_a, 0);

        // clear_i on the window-end cycle suppresses the pulse
        ticks(99);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("up_clr_nopulse", valid_a, 0);
        check("up_clr_hold",    rate_a, 1);
        wait_report(0, 300, n);
        check("up_clr_period", n, 100);
        check("up_clr_rate",   rate_a, 0);

        // Down counter 3 -> 2 -> 1 -> 0 -> 15
        cnt_b = 4'd3;
        ticks(5);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        ticks(4);
        cnt_b = 4'd2;
        ticks(5);
        cnt_b = 4'd1;
        ticks(5);
        cnt_b = 4'd0;
        ticks(5);
        cnt_b = 4'd15;
        wait_report(1, 400, n);
        check("dn_count_rate", rate_b, 4);
        check("dn_count_sat",  sat_b, 0);

        // Random values, hold times and occasional clears
        total = 0;
        while (total < 1500) begin
            cnt_a = 4'($urandom_range(0, 15));
            cnt_b = 4'($urandom_range(0, 15));
            clr_a = ($urandom_range(0, 39) == 0);
            clr_b = ($urandom_range(0, 39) == 0);
            hold  = $urandom_range(1, 8);
            tick();
            clr_a = 1'b0;
            clr_b = 1'b0;
            ticks(hold - 1);
            total += hold;
        end

        // Mid-window asynchronous reset, then the report cadence from release
        ticks(37);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs();
        model_reset();
        ticks(2);
        rst = 1'b0;
        wait_report(0, 300, n);
        check("up_rst_period", n, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule : tb_ripple_ctr_capture
